// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss counter for the oven front panel.
// Counts up as a time-of-day clock or down as a cook timer, supports
// per-digit loading from the switches, and raises done/alarm on expiry.
module bcd_time_counter #(
  parameter int TICK_DIV   = 50000000,
  parameter int HOUR_LIMIT = 24
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        run,
  input  logic        countDown,
  input  logic        loadEn,
  input  logic [2:0]  loadSel,
  input  logic [3:0]  loadValue,
  input  logic        alarmClear,
  output logic [23:0] digits,
  output logic        tick,
  output logic        done,
  output logic        alarm,
  output logic        loadErr
);

  localparam int              PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TC     = PW'(TICK_DIV - 1);
  localparam logic [3:0]      HMAX_T = 4'((HOUR_LIMIT - 1) / 10);
  localparam logic [3:0]      HMAX_O = 4'((HOUR_LIMIT - 1) % 10);
  localparam logic [6:0]      HLIM   = 7'(HOUR_LIMIT);

  // index 0 = secOnes ... index 5 = hourTens, so the packed vector is the output order
  logic [5:0][3:0] r_d;
  logic [PW-1:0]   r_presc;
  logic            r_tick;
  logic            r_done;
  logic            r_alarm;
  logic            r_load_err;

  logic            w_step;
  logic            w_zero;
  logic            w_legal;
  logic [3:0]      w_new_ht;
  logic [3:0]      w_new_ho;
  logic [6:0]      w_hour;
  logic [5:0][3:0] w_next;
  logic            w_c;
  logic            w_advance;
  logic            w_done_set;

  assign w_step     = run && (r_presc == TC);
  assign w_zero     = (r_d == '0);
  // a load on the step cycle wins; at 00:00:00 in down mode the step is swallowed
  assign w_advance  = w_step && !loadEn && !(countDown && w_zero);
  assign w_done_set = w_advance && countDown && (w_next == '0);

  // prescaler: free-runs while enabled, a stopped clock forgets the partial second
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)              r_presc <= '0;
    else if (!run || w_step)  r_presc <= '0;
    else                      r_presc <= r_presc + 1'b1;
  end

  // load legality; the hour check uses the candidate hour in binary
  always_comb begin
    w_new_ht = r_d[5];
    w_new_ho = r_d[4];
    if (loadSel == 3'd5) w_new_ht = loadValue;
    if (loadSel == 3'd4) w_new_ho = loadValue;
    w_hour  = 7'(w_new_ht) * 7'd10 + 7'(w_new_ho);
    w_legal = 1'b0;
    case (loadSel)
      3'd0, 3'd2: w_legal = (loadValue <= 4'd9);
      3'd1, 3'd3: w_legal = (loadValue <= 4'd5);
      3'd4, 3'd5: w_legal = (loadValue <= 4'd9) && (w_hour < HLIM);
      default:    w_legal = 1'b0;
    endcase
  end

  // next BCD value for one step, ripple carry (up) or borrow (down)
  always_comb begin
    w_next = r_d;
    w_c    = 1'b1;
    if (!countDown) begin
      if (r_d[0] == 4'd9) w_next[0] = 4'd0;
      else begin w_next[0] = r_d[0] + 4'd1; w_c = 1'b0; end
      if (w_c) begin
        if (r_d[1] == 4'd5) w_next[1] = 4'd0;
        else begin w_next[1] = r_d[1] + 4'd1; w_c = 1'b0; end
      end
      if (w_c) begin
        if (r_d[2] == 4'd9) w_next[2] = 4'd0;
        else begin w_next[2] = r_d[2] + 4'd1; w_c = 1'b0; end
      end
      if (w_c) begin
        if (r_d[3] == 4'd5) w_next[3] = 4'd0;
        else begin w_next[3] = r_d[3] + 4'd1; w_c = 1'b0; end
      end
      if (w_c) begin
        if (r_d[5] == HMAX_T && r_d[4] == HMAX_O) begin
          w_next[5] = 4'd0;
          w_next[4] = 4'd0;
        end else if (r_d[4] == 4'd9) begin
          w_next[5] = r_d[5] + 4'd1;
          w_next[4] = 4'd0;
        end else begin
          w_next[4] = r_d[4] + 4'd1;
        end
      end
    end else begin
      if (r_d[0] == 4'd0) w_next[0] = 4'd9;
      else begin w_next[0] = r_d[0] - 4'd1; w_c = 1'b0; end
      if (w_c) begin
        if (r_d[1] == 4'd0) w_next[1] = 4'd5;
        else begin w_next[1] = r_d[1] - 4'd1; w_c = 1'b0; end
      end
      if (w_c) begin
        if (r_d[2] == 4'd0) w_next[2] = 4'd9;
        else begin w_next[2] = r_d[2] - 4'd1; w_c = 1'b0; end
      end
      if (w_c) begin
        if (r_d[3] == 4'd0) w_next[3] = 4'd5;
        else begin w_next[3] = r_d[3] - 4'd1; w_c = 1'b0; end
      end
      if (w_c) begin
        if (r_d[5] == 4'd0 && r_d[4] == 4'd0) begin
          w_next[5] = HMAX_T;
          w_next[4] = HMAX_O;
        end else if (r_d[4] == 4'd0) begin
          w_next[5] = r_d[5] - 4'd1;
          w_next[4] = 4'd9;
        end else begin
          w_next[4] = r_d[4] - 4'd1;
        end
      end
    end
  end

  // digit register and the one-cycle status pulses
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_d        <= '0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
      if (loadEn) begin
        if (w_legal) begin
          for (int i = 0; i < 6; i++)
            if (loadSel == 3'(i)) r_d[i] <= loadValue;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (w_advance) begin
        r_d    <= w_next;
        r_tick <= 1'b1;
        r_done <= w_done_set;
      end
    end
  end

  // sticky alarm; a new expiry beats a simultaneous clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)         r_alarm <= 1'b0;
    else if (w_done_set) r_alarm <= 1'b1;
    else if (alarmClear) r_alarm <= 1'b0;
  end

  assign digits  = r_d;
  assign tick    = r_tick;
  assign done    = r_done;
  assign alarm   = r_alarm;
  assign loadErr = r_load_err;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter: the reference model keeps time as
// plain seconds-since-midnight and derives digits arithmetically.
module tb_bcd_time_counter;
  localparam int TD = 4;
  localparam int HL = 24;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        run = 1'b0;
  logic        countDown = 1'b0;
  logic        loadEn = 1'b0;
  logic [2:0]  loadSel = 3'd0;
  logic [3:0]  loadValue = 4'd0;
  logic        alarmClear = 1'b0;
  logic [23:0] digits;
  logic        tick, done, alarm, loadErr;

  bcd_time_counter #(.TICK_DIV(TD), .HOUR_LIMIT(HL)) dut (
    .clk(clk), .resetN(resetN), .run(run), .countDown(countDown),
    .loadEn(loadEn), .loadSel(loadSel), .loadValue(loadValue),
    .alarmClear(alarmClear), .digits(digits), .tick(tick), .done(done),
    .alarm(alarm), .loadErr(loadErr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_edge  = 0;

  always @(posedge clk) n_edge <= n_edge + 1;

  typedef struct {
    int          cyc;
    logic [23:0] dg;
    bit          tk, dn, al, le;
  } exp_t;
  exp_t sb[$];

  // reference model state
  int m_t  = 0;
  int m_ph = 0;
  bit m_al = 1'b0;
  bit cd_r = 1'b0;

  function automatic logic [23:0] to_bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit cd, input bit ld, input int sel,
                            input int val, input bit clr,
                            output bit tk, output bit dn, output bit le);
    bit step, legal;
    int d[6];
    tk = 0; dn = 0; le = 0;
    step = r && (m_ph == TD - 1);
    m_ph = (!r || step) ? 0 : m_ph + 1;
    if (ld) begin
      d[0] = (m_t % 60) % 10;        d[1] = (m_t % 60) / 10;
      d[2] = ((m_t / 60) % 60) % 10; d[3] = ((m_t / 60) % 60) / 10;
      d[4] = (m_t / 3600) % 10;      d[5] = (m_t / 3600) / 10;
      legal = (sel < 6) && (val <= 9) && !((sel == 1 || sel == 3) && val > 5);
      if (legal) begin
        d[sel] = val;
        if (d[5] * 10 + d[4] >= HL) legal = 0;
      end
      if (legal) m_t = (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
      else       le = 1;
    end else if (step) begin
      if (!cd) begin
        m_t = (m_t + 1) % (HL * 3600);
        tk = 1;
      end else if (m_t > 0) begin
        m_t = m_t - 1;
        tk = 1;
        dn = (m_t == 0);
      end
    end
    if (dn)       m_al = 1;
    else if (clr) m_al = 0;
  endtask

  // one clock: verify the settled state, drive inputs, predict the coming edge
  task automatic cyc(input bit r, input bit cd, input bit ld, input int sel,
                     input int val, input bit clr);
    bit tk, dn, le;
    exp_t e;
    @(negedge clk);
    check("digits", digits, to_bcd(m_t));
    check("alarm", 24'(alarm), 24'(m_al));
    run = r; countDown = cd; loadEn = ld;
    loadSel = 3'(sel); loadValue = 4'(val); alarmClear = clr;
    model_edge(r, cd, ld, sel, val, clr, tk, dn, le);
    if (tk || dn || le) begin
      e.cyc = n_edge + 1; e.dg = to_bcd(m_t);
      e.tk = tk; e.dn = dn; e.al = m_al; e.le = le;
      sb.push_back(e);
    end
  endtask

  task automatic load_hms(input int h, input int m, input int s, input bit cd);
    cyc(0, cd, 1, 5, 0, 0);
    cyc(0, cd, 1, 4, h % 10, 0);
    cyc(0, cd, 1, 5, h / 10, 0);
    cyc(0, cd, 1, 3, m / 10, 0);
    cyc(0, cd, 1, 2, m % 10, 0);
    cyc(0, cd, 1, 1, s / 10, 0);
    cyc(0, cd, 1, 0, s % 10, 0);
    cyc(0, cd, 0, 0, 0, 0);
  endtask

  task automatic async_reset_check();
    #2 resetN = 1'b0;
    #1;
    check("rst_digits", digits, 24'd0);
    check("rst_tick", 24'(tick), 24'd0);
    check("rst_done", 24'(done), 24'd0);
    check("rst_alarm", 24'(alarm), 24'd0);
    check("rst_loadErr", 24'(loadErr), 24'd0);
    sb.delete();
    @(negedge clk);
    run = 0; loadEn = 0; alarmClear = 0; countDown = 0;
    resetN = 1'b1;
    m_t = 0; m_ph = 0; m_al = 0;
  endtask

  // monitor: compares whenever the DUT presents a pulse or a prediction is due
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == n_edge) begin
        e = sb.pop_front();
        check("sb_tick", 24'(tick), 24'(e.tk));
        check("sb_done", 24'(done), 24'(e.dn));
        check("sb_loadErr", 24'(loadErr), 24'(e.le));
        check("sb_digits", digits, e.dg);
        check("sb_alarm", 24'(alarm), 24'(e.al));
      end else if (resetN) begin
        check("idle_pulses", {21'd0, tick, done, loadErr}, 24'd0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_digits0", digits, 24'd0);
    check("rst_pulses0", {20'd0, tick, done, alarm, loadErr}, 24'd0);
    resetN = 1'b1;

    // first tick four cycles after run, then reset right on a pending tick
    repeat (9) cyc(1, 0, 0, 0, 0, 0);
    while (m_ph != TD - 1) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    async_reset_check();

    // up-count wrap
    load_hms(23, 59, 59, 0);
    repeat (TD + 2) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // countdown expiry, freeze at zero, clear
    load_hms(0, 1, 0, 1);
    repeat (62 * TD) cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);

    // borrow chain
    load_hms(1, 0, 0, 1);
    repeat (TD) cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);

    // illegal loads
    cyc(0, 0, 1, 1, 6, 0);
    load_hms(5, 0, 0, 0);
    cyc(0, 0, 1, 5, 2, 0);
    cyc(0, 0, 1, 7, 3, 0);
    cyc(0, 0, 1, 6, 1, 0);
    cyc(0, 0, 1, 0, 10, 0);
    cyc(0, 0, 1, 4, 10, 0);
    cyc(0, 0, 1, 3, 10, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // load on a step cycle
    load_hms(0, 0, 10, 0);
    repeat (TD - 1) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 7, 0);
    repeat (TD + 1) cyc(1, 0, 0, 0, 0, 0);

    // clear on the done cycle: set wins
    load_hms(0, 0, 1, 1);
    repeat (TD - 1) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);

    // switching to down mode at zero gives no done
    load_hms(0, 0, 0, 0);
    repeat (3 * TD) cyc(1, 1, 0, 0, 0, 0);

    // randomized operation
    cd_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        cd_r = 1;
        load_hms(0, $urandom_range(0, 1), $urandom_range(0, 5), 1);
      end
      if ($urandom_range(0, 49) == 0) cd_r = ~cd_r;
      cyc($urandom_range(0, 9) != 0, cd_r, $urandom_range(0, 39) == 0,
          $urandom_range(0, 7), $urandom_range(0, 10), $urandom_range(0, 29) == 0);
    end

    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 24'(sb.size()), 24'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Parametrised successor of the oven's minute/hour clock counter.
- Keeps a BCD hours:minutes:seconds value that counts up as a time-of-day clock or counts down as a cook timer.
- Supports per-digit loading from the switch inputs, and raises a done/alarm indication when the countdown expires.
- Sits between the board clock/switch inputs and the seven-segment decoders, which consume its six BCD digits.

Parameters:
- TICK_DIV, 50000000, clk cycles per counted second (minimum 2).
- HOUR_LIMIT, 24, hour modulus; the hour field counts 0..HOUR_LIMIT-1 (legal range 2..99).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = counting enabled.
- countDown  in  1  mode; 1 = cook-timer countdown, 0 = clock count-up.
- loadEn  in  1  single-cycle strobe; writes loadValue into the digit selected by loadSel.
- loadSel  in  3  digit index: 0 secOnes, 1 secTens, 2 minOnes, 3 minTens, 4 hourOnes, 5 hourTens; 6–7 are illegal.
- loadValue  in  4  BCD value to load.
- alarmClear  in  1  clears alarm.
- digits  out  24  {hourTens, hourOnes, minTens, minOnes, secTens, secOnes}, 4 bits each, registered.
- tick  out  1  one-cycle pulse when digits advance.
- done  out  1  one-cycle pulse when the countdown reaches 00:00:00.
- alarm  out  1  sticky level, set by done.
- loadErr  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (resetN=0, async):
  - Prescaler = 0; digits = 0.
  - tick, done, alarm, loadErr all = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run=1; is held at 0 while run=0.
  - The terminal-count cycle (prescaler = TICK_DIV-1 and run=1) is the "step" event; the prescaler returns to 0 on the next edge.
- Step, up mode (countDown=0):
  - Ripple-increment in BCD: secOnes 9→0 carries into secTens; secTens 5→0 carries into minutes; the minute fields behave the same way.
  - Hours wrap HOUR_LIMIT-1 → 0, so 23:59:59 → 00:00:00 with the default.
- Step, down mode (countDown=1):
  - Ripple-decrement with borrow: sec/min fields go 00 → 59; hours go 0 → HOUR_LIMIT-1 on borrow.
  - The decrement is suppressed if the value is already 00:00:00. Digits freeze at zero; no tick and no done.
- Output timing:
  - Digits update on the edge ending the step cycle.
  - tick is registered high for exactly the following cycle, aligned with the new digits.
- done:
  - Registered pulse in the same cycle as tick, asserted only when a down-mode step produced 00:00:00 from a non-zero value.
  - alarm sets on that same edge.
- alarm:
  - Stays 1 until alarmClear=1 is sampled.
  - If set and clear occur on the same edge, set wins.
  - alarm is not cleared by a load.
- Load legality, checked on the loadEn cycle:
  - Ones digits must be ≤ 9.
  - secTens and minTens must be ≤ 5.
  - The resulting hour value (hourTens*10 + hourOnes, using the new digit) must be < HOUR_LIMIT.
  - loadSel 6–7 is illegal.
  - A legal load updates the digit on that edge.
  - An illegal load leaves all digits unchanged and pulses loadErr in the next cycle.
- Load vs step, same cycle:
  - The load takes priority and the step is discarded: no digit change from the step, no tick, no done.
  - The prescaler still wraps to 0.
- Mode change:
  - countDown is sampled only on step cycles, so a change mid-second takes effect at the next step.
  - Switching to down mode at 00:00:00 produces no done.
- run deasserted mid-second:
  - The prescaler clears, so the partial second is lost.
  - Digits and alarm hold.
- Reset mid-operation clears everything immediately, including a pending tick, done or loadErr.
- Width rules:
  - Prescaler width is clog2(TICK_DIV).
  - The hour comparison is done in binary on the 7-bit value tens*10+ones.

Test Plan:
- Reset with TICK_DIV=4: assert resetN=0 mid-count → digits=0 and all pulses 0 asynchronously; after release, the first tick occurs 4 cycles after run=1.
- Up-count wrap: load 23:59:59, run=1, countDown=0 → after one step digits=00:00:00 and tick=1; done stays 0.
- Countdown expiry: load 00:01:00, countDown=1, run=1 → the 60th step gives 00:00:00 with tick=done=1 on the same cycle and alarm=1; further steps keep 00:00:00 with no tick; alarmClear → alarm=0.
- Borrow chain: load 01:00:00 in down mode → one step gives 00:59:59.
- Illegal loads (loadErr=1 and digits unchanged in each case):
  - loadSel=1 with value 6.
  - loadSel=5 with value 2 while hourOnes=5 (gives 25 ≥ 24).
  - loadSel=7.
  - Any digit with value 10.
- Collisions:
  - loadEn on a step cycle → the loaded value appears with no tick.
  - alarmClear on the same cycle a done occurs → alarm=1.
